// File: rtl/regfile_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_sb_if : decode-stage bus between the hazard unit and regfile_sb    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        rbusy;
  logic                  we;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     wd;
  logic                  iv;
  logic [ADDR_W-1:0]     ia;
  logic                  clr;
  logic                  rdy;

  modport master (output ra, we, wa, wd, iv, ia, clr, input rd, rbusy, rdy);
  modport slave  (input ra, we, wa, wd, iv, ia, clr, output rd, rbusy, rdy);
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_sb : register file with write-through bypass, busy scoreboard and  |
// |              a DEPTH-cycle soft-clear sweep.                               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  regfile_sb_if.slave bus
);
  localparam int                c_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [c_DEPTH-1:0]  r_busy;

  logic                w_idle;
  logic                w_wr_en;
  logic                w_iss_en;
  logic [NRD*DATA_W-1:0] w_rd;
  logic [NRD-1:0]      w_rbusy;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_en  = w_idle && bus.we && !((ZERO_REG != 0) && (bus.wa == '0));
  assign w_iss_en = w_idle && bus.iv && !((ZERO_REG != 0) && (bus.ia == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.clr) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == c_LAST) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Issue is applied after the write-side clear so a same-address set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else if (!w_idle) begin
      r_mem[r_idx]  <= '0;
      r_busy[r_idx] <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[bus.wa] <= bus.wd;
      end
      if (bus.we) begin
        r_busy[bus.wa] <= 1'b0;
      end
      if (w_iss_en) begin
        r_busy[bus.ia] <= 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_zero;
      logic              w_byp;

      assign w_ra   = bus.ra[k*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
      assign w_byp  = (BYPASS != 0) && bus.we && (bus.wa == w_ra);

      assign w_rd[k*DATA_W +: DATA_W] = (!w_idle || w_zero) ? '0 :
                                        w_byp               ? bus.wd :
                                                              r_mem[w_ra];
      assign w_rbusy[k] = w_idle && !w_zero && !w_byp && r_busy[w_ra];
    end
  endgenerate

  assign bus.rd    = w_rd;
  assign bus.rbusy = w_rbusy;
  assign bus.rdy   = w_idle;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_sb : two regfile_sb configurations driven in lockstep and       |
// |                 compared against a behavioural register-file model.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_regfile_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] ra;
  logic             we, iv, clr;
  logic [AW-1:0]    wa, ia;
  logic [DW-1:0]    wd;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) ifa ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) ifb ();

  assign ifa.ra = ra;  assign ifa.we = we;  assign ifa.wa = wa;  assign ifa.wd = wd;
  assign ifa.iv = iv;  assign ifa.ia = ia;  assign ifa.clr = clr;
  assign ifb.ra = ra;  assign ifb.we = we;  assign ifb.wa = wa;  assign ifb.wd = wd;
  assign ifb.iv = iv;  assign ifb.ia = ia;  assign ifb.clr = clr;

  // dut_a: bypass + zero register; dut_b: neither
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_REG(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  logic [NR*DW-1:0] rd_o  [2];
  logic [NR-1:0]    rb_o  [2];
  logic             rdy_o [2];
  assign rd_o[0] = ifa.rd;  assign rb_o[0] = ifa.rbusy;  assign rdy_o[0] = ifa.rdy;
  assign rd_o[1] = ifb.rd;  assign rb_o[1] = ifb.rbusy;  assign rdy_o[1] = ifb.rdy;

  int nvec = 0;
  int nerr = 0;

  // Reference model: contents, busy flags and remaining sweep cycles per DUT
  logic [DW-1:0] mmem   [2][DEPTH];
  bit            mbusy  [2][DEPTH];
  int            msweep [2];

  function automatic bit cfg_bp(int d); return (d == 0); endfunction
  function automatic bit cfg_zr(int d); return (d == 0); endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      msweep[d] = 0;
      for (int r = 0; r < DEPTH; r++) begin
        mmem[d][r]  = '0;
        mbusy[d][r] = 1'b0;
      end
    end
  endfunction

  function automatic void m_clock();
    for (int d = 0; d < 2; d++) begin
      if (msweep[d] > 0) begin
        mmem[d][DEPTH - msweep[d]]  = '0;
        mbusy[d][DEPTH - msweep[d]] = 1'b0;
        msweep[d]--;
      end else begin
        if (we && !(cfg_zr(d) && wa == 0)) mmem[d][wa] = wd;
        if (we) mbusy[d][wa] = 1'b0;
        if (iv && !(cfg_zr(d) && ia == 0)) mbusy[d][ia] = 1'b1;
        if (clr) msweep[d] = DEPTH;
      end
    end
  endfunction

  function automatic logic [DW-1:0] m_rd(int d, logic [AW-1:0] a);
    if (msweep[d] > 0) return '0;
    if (cfg_zr(d) && a == 0) return '0;
    if (cfg_bp(d) && we && wa == a) return wd;
    return mmem[d][a];
  endfunction

  function automatic bit m_busy(int d, logic [AW-1:0] a);
    if (msweep[d] > 0) return 1'b0;
    if (cfg_zr(d) && a == 0) return 1'b0;
    if (cfg_bp(d) && we && wa == a) return 1'b0;
    return mbusy[d][a];
  endfunction

  function automatic bit m_rdy(int d); return (msweep[d] == 0); endfunction

  task automatic set_in(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dat,
                        input logic i, input logic [AW-1:0] ai, input logic c,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    we = w; wa = a; wd = dat; iv = i; ia = ai; clr = c; ra = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd31);
    m_reset();
    repeat (2) @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (rd_o[d] !== '0) begin
        nerr++; $display("FAIL reset_rd dut%0d got=%h exp=0", d, rd_o[d]);
      end
      nvec++;
      if (rb_o[d] !== '0) begin
        nerr++; $display("FAIL reset_rbusy dut%0d got=%b exp=0", d, rb_o[d]);
      end
      nvec++;
      if (rdy_o[d] !== 1'b1) begin
        nerr++; $display("FAIL reset_rdy dut%0d got=%b exp=1", d, rdy_o[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    set_in(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd7, 5'd1);
    #3;
    nvec++;
    if (rd_o[0][DW-1:0] !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL bypass_rd dut0 got=%h exp=deadbeef", rd_o[0][DW-1:0]);
    end
    nvec++;
    if (rd_o[1][DW-1:0] !== 32'h0) begin
      nerr++; $display("FAIL nobypass_rd dut1 got=%h exp=0", rd_o[1][DW-1:0]);
    end
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    #3;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NR; k++) begin
        nvec++;
        if (rd_o[d][k*DW +: DW] !== 32'hDEADBEEF) begin
          nerr++; $display("FAIL write_read dut%0d rd%0d got=%h exp=deadbeef", d, k, rd_o[d][k*DW +: DW]);
        end
      end
    end
    tick();
  endtask

  task automatic test_zero_reg();
    set_in(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    #3;
    nvec++;
    if (rd_o[0][DW-1:0] !== 32'h0 || rb_o[0][0] !== 1'b0) begin
      nerr++; $display("FAIL zero_reg dut0 got=%h/%b exp=0/0", rd_o[0][DW-1:0], rb_o[0][0]);
    end
    nvec++;
    if (rd_o[1][DW-1:0] !== m_rd(1, 5'd0) || rb_o[1][0] !== m_busy(1, 5'd0)) begin
      nerr++; $display("FAIL zero_reg_plain dut1 got=%h/%b exp=%h/%b", rd_o[1][DW-1:0], rb_o[1][0],
                       m_rd(1, 5'd0), m_busy(1, 5'd0));
    end
    tick();
  endtask

  task automatic test_scoreboard();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    #3;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (rb_o[d] !== 2'b11) begin
        nerr++; $display("FAIL busy_set dut%0d got=%b exp=11", d, rb_o[d]);
      end
    end
    tick();
    set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    #3;
    nvec++;
    if (rb_o[0] !== 2'b00) begin
      nerr++; $display("FAIL busy_clr_bypass dut0 got=%b exp=00", rb_o[0]);
    end
    nvec++;
    if (rb_o[1] !== 2'b11) begin
      nerr++; $display("FAIL busy_clr_nobypass dut1 got=%b exp=11", rb_o[1]);
    end
    tick();
    set_in(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 5'd9, 5'd3);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd3);
    #3;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (rb_o[d] !== 2'b01 || rd_o[d][DW-1:0] !== 32'h99) begin
        nerr++; $display("FAIL set_wins dut%0d got=%b/%h exp=01/99", d, rb_o[d], rd_o[d][DW-1:0]);
      end
    end
    tick();
  endtask

  task automatic test_clear_sweep();
    int cnt;
    for (int r = 1; r < DEPTH; r++) begin
      set_in(1'b1, 5'(r), 32'(r), 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      tick();
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd2);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd2);
    #3;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (rb_o[d][0] !== 1'b1 || rd_o[d][2*DW-1:DW] !== 32'd2) begin
        nerr++; $display("FAIL pre_clear dut%0d got=%b/%h exp=1/2", d, rb_o[d][0], rd_o[d][2*DW-1:DW]);
      end
    end
    tick();
    cnt = 0;
    while (cnt < 100) begin
      set_in(cnt == 5, 5'd2, 32'hFFFF0002, cnt == 6, 5'd7, cnt == 7, 5'(cnt), 5'd2);
      #3;
      if (rdy_o[0] === 1'b1) break;
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (rdy_o[d] !== m_rdy(d) || rd_o[d] !== {m_rd(d, 5'd2), m_rd(d, 5'(cnt))}
            || rb_o[d] !== {m_busy(d, 5'd2), m_busy(d, 5'(cnt))}) begin
          nerr++; $display("FAIL sweep dut%0d cyc%0d got=%b/%h/%b exp=%b/0/00", d, cnt, rdy_o[d], rd_o[d],
                           rb_o[d], m_rdy(d));
        end
      end
      cnt++;
      tick();
    end
    nvec++;
    if (cnt != DEPTH || rdy_o[1] !== 1'b1) begin
      nerr++; $display("FAIL sweep_len got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int r = 0; r < DEPTH; r += 2) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'(r), 5'(r + 1));
      #3;
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (rd_o[d] !== '0 || rb_o[d] !== '0) begin
          nerr++; $display("FAIL post_clear dut%0d r%0d got=%h/%b exp=0/0", d, r, rd_o[d], rb_o[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    set_in(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 1'b0, 5'd20, 5'd1);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd1);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd1);
    repeat (9) tick();
    #1;
    nvec++;
    if (rdy_o[0] !== 1'b0) begin
      nerr++; $display("FAIL mid_sweep_rdy got=%b exp=0", rdy_o[0]);
    end
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (rdy_o[d] !== 1'b1 || rd_o[d][DW-1:0] !== 32'h0) begin
        nerr++; $display("FAIL async_reset dut%0d got=%b/%h exp=1/0", d, rdy_o[d], rd_o[d][DW-1:0]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b1, 5'd1, 32'hA5A50001, 1'b0, 5'd0, 1'b0, 5'd20, 5'd1);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd1);
    #3;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (rd_o[d] !== {32'hA5A50001, 32'h0} || rdy_o[d] !== 1'b1) begin
        nerr++; $display("FAIL post_reset_write dut%0d got=%h/%b exp=a5a5000100000000/1", d, rd_o[d], rdy_o[d]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] a, r0, r1;
    for (int n = 0; n < 400; n++) begin
      a  = 5'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      set_in(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
             $urandom_range(0, 59) == 0, r0, r1);
      #3;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NR; k++) begin
          nvec++;
          if (rd_o[d][k*DW +: DW] !== m_rd(d, ra[k*AW +: AW])) begin
            nerr++; $display("FAIL rand_rd n%0d dut%0d rd%0d got=%h exp=%h", n, d, k, rd_o[d][k*DW +: DW],
                             m_rd(d, ra[k*AW +: AW]));
          end
          nvec++;
          if (rb_o[d][k] !== m_busy(d, ra[k*AW +: AW])) begin
            nerr++; $display("FAIL rand_rbusy n%0d dut%0d rb%0d got=%b exp=%b", n, d, k, rb_o[d][k],
                             m_busy(d, ra[k*AW +: AW]));
          end
        end
        nvec++;
        if (rdy_o[d] !== m_rdy(d)) begin
          nerr++; $display("FAIL rand_rdy n%0d dut%0d got=%b exp=%b", n, d, rdy_o[d], m_rdy(d));
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_clear_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire
